// File: rtl/sar_adc_ctrl_if.sv
// Host-side handshake bundle for the SAR ADC controller: enable, start,
// busy indication and the valid/ready result channel.
interface sar_adc_ctrl_if #(
  parameter int NBITS = 8
);
  logic             ena;
  logic             start;
  logic             busy;
  logic             valid;
  logic             ready;
  logic [NBITS-1:0] result;

  // Host / consumer side
  modport master (
    output ena,
    output start,
    output ready,
    input  busy,
    input  valid,
    input  result
  );

  // Controller side
  modport slave (
    input  ena,
    input  start,
    input  ready,
    output busy,
    output valid,
    output result
  );
endinterface

// File: rtl/sar_adc_ctrl.sv
// Successive-approximation ADC controller. Tracks the input, then resolves
// one bit per trial from MSB to LSB using a synchronized comparator, and
// hands the final code to the consumer over a valid/ready handshake.
module sar_adc_ctrl #(
  parameter int NBITS      = 8,
  parameter int SAMPLE_CYC = 4,
  parameter int SETTLE_CYC = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  sar_adc_ctrl_if.slave    bus,
  input  logic             cmp_in,
  output logic             sample,
  output logic [NBITS-1:0] dac_code
);

  localparam int              IW          = (NBITS > 1) ? $clog2(NBITS) : 1;
  // SAMPLE spends one entry cycle plus SAMPLE_CYC tracking cycles
  localparam logic [4:0]      SAMPLE_LAST = 5'(SAMPLE_CYC);
  // SETTLE spends SETTLE_CYC + 2 cycles, the 2 covering synchronizer delay
  localparam logic [4:0]      SETTLE_LAST = 5'(SETTLE_CYC + 1);
  localparam logic [IW-1:0]   TOP_BIT     = IW'(NBITS - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SAMPLE = 3'd1,
    SETTLE = 3'd2,
    DECIDE = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t           state_r, state_s;
  logic [4:0]       cnt_r, cnt_s;
  logic [IW-1:0]    bit_r, bit_s;
  logic [NBITS-1:0] dac_r, dac_s;
  logic [NBITS-1:0] result_r, result_s;
  logic [NBITS-1:0] kept_s;
  logic             sample_r, sample_s;
  logic             valid_r, valid_s;
  logic             busy_r, busy_s;
  logic             cmp_meta_r;
  logic             cmp_s;

  // One-hot mask selecting bit idx of the trial code
  function automatic logic [NBITS-1:0] bit_mask(input logic [IW-1:0] idx);
    bit_mask = {{(NBITS-1){1'b0}}, 1'b1} << idx;
  endfunction

  // Two-flop synchronizer for the asynchronous comparator output
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmp_meta_r <= 1'b0;
      cmp_s      <= 1'b0;
    end else begin
      cmp_meta_r <= cmp_in;
      cmp_s      <= cmp_meta_r;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next state and next values of all registered outputs and counters
  always_comb begin
    state_s  = state_r;
    cnt_s    = cnt_r;
    bit_s    = bit_r;
    dac_s    = dac_r;
    sample_s = sample_r;
    valid_s  = valid_r;
    result_s = result_r;
    kept_s   = '0;
    if (!bus.ena) begin
      // Abort: drop any partial conversion, result keeps its last value
      state_s  = IDLE;
      cnt_s    = 5'd0;
      bit_s    = '0;
      dac_s    = '0;
      sample_s = 1'b0;
      valid_s  = 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          cnt_s    = 5'd0;
          bit_s    = '0;
          dac_s    = '0;
          sample_s = 1'b0;
          valid_s  = 1'b0;
          if (bus.start) begin
            state_s = SAMPLE;
          end else begin
            state_s = IDLE;
          end
        end
        SAMPLE: begin
          if (cnt_r == SAMPLE_LAST) begin
            state_s  = SETTLE;
            cnt_s    = 5'd0;
            sample_s = 1'b0;
            bit_s    = TOP_BIT;
            dac_s    = bit_mask(TOP_BIT);
          end else begin
            cnt_s    = cnt_r + 5'd1;
            sample_s = 1'b1;
          end
        end
        SETTLE: begin
          if (cnt_r == SETTLE_LAST) begin
            state_s = DECIDE;
            cnt_s   = 5'd0;
          end else begin
            cnt_s   = cnt_r + 5'd1;
          end
        end
        DECIDE: begin
          // Keep the trial bit only if Vin >= Vdac
          if (cmp_s) begin
            kept_s = dac_r;
          end else begin
            kept_s = dac_r & ~bit_mask(bit_r);
          end
          if (bit_r != '0) begin
            state_s = SETTLE;
            bit_s   = bit_r - IW'(1);
            dac_s   = kept_s | bit_mask(bit_r - IW'(1));
          end else begin
            state_s  = DONE;
            result_s = kept_s;
            valid_s  = 1'b1;
            dac_s    = '0;
          end
        end
        DONE: begin
          if (bus.ready) begin
            state_s = IDLE;
            valid_s = 1'b0;
          end else begin
            state_s = DONE;
            valid_s = 1'b1;
          end
        end
        default: begin
          state_s  = IDLE;
          cnt_s    = 5'd0;
          bit_s    = '0;
          dac_s    = '0;
          sample_s = 1'b0;
          valid_s  = 1'b0;
        end
      endcase
    end
    busy_s = (state_s != IDLE);
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r    <= 5'd0;
      bit_r    <= '0;
      dac_r    <= '0;
      result_r <= '0;
      sample_r <= 1'b0;
      valid_r  <= 1'b0;
      busy_r   <= 1'b0;
    end else begin
      cnt_r    <= cnt_s;
      bit_r    <= bit_s;
      dac_r    <= dac_s;
      result_r <= result_s;
      sample_r <= sample_s;
      valid_r  <= valid_s;
      busy_r   <= busy_s;
    end
  end

  assign sample     = sample_r;
  assign dac_code   = dac_r;
  assign bus.busy   = busy_r;
  assign bus.valid  = valid_r;
  assign bus.result = result_r;

endmodule

// File: tb/tb_sar_adc_ctrl.sv
// Bench for sar_adc_ctrl: a default 8-bit instance and a small 4-bit
// instance, driven by an ideal comparator and checked against a
// binary-search reference model.
module tb_sar_adc_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  sar_adc_ctrl_if #(.NBITS(8)) bus_a ();
  sar_adc_ctrl_if #(.NBITS(4)) bus_b ();

  logic       sample_a, sample_b, cmp_a, cmp_b;
  logic [7:0] dac_a;
  logic [3:0] dac_b;

  int vin_a, vin_b;
  int tie;        // 0: ideal comparator, 1: tied 0, 2: tied 1
  int sel;        // 0: 8-bit instance, 1: 4-bit instance
  int last_res_a;
  int n_checks = 0;
  int n_errors = 0;

  assign cmp_a = (tie == 2) ? 1'b1 : (tie == 1) ? 1'b0 : (vin_a >= int'(dac_a));
  assign cmp_b = (tie == 2) ? 1'b1 : (tie == 1) ? 1'b0 : (vin_b >= int'(dac_b));

  int m_dac, m_result;
  logic m_sample, m_valid, m_busy;
  assign m_dac    = (sel != 0) ? int'(dac_b) : int'(dac_a);
  assign m_result = (sel != 0) ? int'(bus_b.result) : int'(bus_a.result);
  assign m_sample = (sel != 0) ? sample_b : sample_a;
  assign m_valid  = (sel != 0) ? bus_b.valid : bus_a.valid;
  assign m_busy   = (sel != 0) ? bus_b.busy : bus_a.busy;

  sar_adc_ctrl dut_a (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus_a),
    .cmp_in   (cmp_a),
    .sample   (sample_a),
    .dac_code (dac_a)
  );

  sar_adc_ctrl #(.NBITS(4), .SAMPLE_CYC(1), .SETTLE_CYC(0)) dut_b (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus_b),
    .cmp_in   (cmp_b),
    .sample   (sample_b),
    .dac_code (dac_b)
  );

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: ideal binary search. idx < nb gives the idx-th trial code,
  // idx == nb gives the final code.
  function automatic int sar_model(input int vin, input int nb, input int idx);
    int code = 0;
    int t    = 0;
    for (int b = nb - 1; b >= 0; b--) begin
      t = code | (1 << b);
      if (nb - 1 - b == idx) return t;
      if (vin >= t) code = t;
    end
    return code;
  endfunction

  task automatic pulse_start();
    @(negedge clk);
    if (sel != 0) bus_b.start = 1'b1; else bus_a.start = 1'b1;
    @(posedge clk);
    #1;
    bus_a.start = 1'b0;
    bus_b.start = 1'b0;
  endtask

  // Full conversion with ready=1: latency, result, sample width, trial order
  task automatic convert(input int s, input int vin, input int tmode, input string tag);
    int nb, lat_exp, smp_exp, vin_eff, code, lat, res, smp, prev;
    int trials[$];
    sel = s;
    nb      = (s != 0) ? 4 : 8;
    lat_exp = (s != 0) ? 14 : 45;
    smp_exp = (s != 0) ? 1 : 4;
    vin_eff = (tmode == 2) ? (1 << nb) - 1 : (tmode == 1) ? 0 : vin;
    code    = sar_model(vin_eff, nb, nb);
    tie = tmode;
    if (s != 0) vin_b = vin; else vin_a = vin;
    lat = -1; res = -1; smp = 0; prev = 0;
    pulse_start();
    for (int n = 1; n <= lat_exp + 20 && lat < 0; n++) begin
      @(posedge clk);
      #1;
      if (m_sample) smp++;
      if (m_dac != prev && m_dac != 0) trials.push_back(m_dac);
      prev = m_dac;
      if (m_valid) begin
        lat = n;
        res = m_result;
      end
    end
    check({tag, "_latency"}, lat, lat_exp);
    check({tag, "_result"}, res, code);
    check({tag, "_sample_cycles"}, smp, smp_exp);
    check({tag, "_trial_count"}, trials.size(), nb);
    for (int i = 0; i < nb; i++) begin
      check({tag, "_trial"}, (i < trials.size()) ? trials[i] : -1, sar_model(vin_eff, nb, i));
    end
    @(posedge clk);
    #1;
    check({tag, "_valid_cleared"}, m_valid, 0);
    check({tag, "_idle_after_ack"}, m_busy, 0);
    if (s == 0) last_res_a = code;
    tie = 0;
  endtask

  // ready held low 20 cycles with a stray start in the middle
  task automatic hold_test(input int vin);
    int lat = -1;
    int stable = 1;
    int code;
    sel = 0; tie = 0; vin_a = vin;
    code = sar_model(vin, 8, 8);
    bus_a.ready = 1'b0;
    pulse_start();
    for (int n = 1; n <= 80 && lat < 0; n++) begin
      @(posedge clk);
      #1;
      if (bus_a.valid) lat = n;
    end
    check("hold_latency", lat, 45);
    for (int c = 0; c < 20; c++) begin
      bus_a.start = (c == 5) ? 1'b1 : 1'b0;
      @(posedge clk);
      #1;
      if (!(bus_a.valid === 1'b1 && int'(bus_a.result) === code && bus_a.busy === 1'b1)) stable = 0;
    end
    bus_a.start = 1'b0;
    check("hold_stable", stable, 1);
    bus_a.ready = 1'b1;
    @(posedge clk);
    #1;
    check("hold_ack_valid", bus_a.valid, 0);
    check("hold_ack_idle", bus_a.busy, 0);
    check("hold_result_kept", bus_a.result, code);
    repeat (5) @(posedge clk);
    #1;
    check("hold_no_queued_start", bus_a.busy, 0);
    last_res_a = code;
  endtask

  // ena dropped in the bit-3 trial
  task automatic abort_test(input int vin);
    int never = 1;
    sel = 0; tie = 0; vin_a = vin;
    pulse_start();
    repeat (26) @(posedge clk);
    #1;
    check("abort_pre_dac", m_dac, sar_model(vin, 8, 4));
    bus_a.ena = 1'b0;
    @(posedge clk);
    #1;
    check("abort_busy", bus_a.busy, 0);
    check("abort_dac", dac_a, 0);
    check("abort_sample", sample_a, 0);
    check("abort_valid", bus_a.valid, 0);
    bus_a.ena = 1'b1;
    for (int c = 0; c < 60; c++) begin
      @(posedge clk);
      #1;
      if (bus_a.valid) never = 0;
    end
    check("abort_never_valid", never, 1);
    check("abort_result_kept", bus_a.result, last_res_a);
    check("abort_idle", bus_a.busy, 0);
  endtask

  // Asynchronous reset in the middle of a SETTLE cycle
  task automatic reset_test(input int vin);
    sel = 0; tie = 0; vin_a = vin;
    pulse_start();
    repeat (8) @(posedge clk);
    #1;
    check("rst_pre_dac", dac_a, 8'h80);
    check("rst_pre_busy", bus_a.busy, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_async_sample", sample_a, 0);
    check("rst_async_dac", dac_a, 0);
    check("rst_async_busy", bus_a.busy, 0);
    check("rst_async_valid", bus_a.valid, 0);
    check("rst_async_result", bus_a.result, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    last_res_a = 0;
  endtask

  // Hard time limit so the run always terminates
  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    bus_a.ena = 1'b1; bus_a.start = 1'b0; bus_a.ready = 1'b1;
    bus_b.ena = 1'b1; bus_b.start = 1'b0; bus_b.ready = 1'b1;
    vin_a = 0; vin_b = 0; tie = 0; sel = 0; last_res_a = 0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_sample", sample_a, 0);
    check("reset_dac", dac_a, 0);
    check("reset_busy", bus_a.busy, 0);
    check("reset_valid", bus_a.valid, 0);
    check("reset_result", bus_a.result, 0);
    check("reset_b_busy", bus_b.busy, 0);
    check("reset_b_valid", bus_b.valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    convert(0, 'hA5, 0, "a5");
    convert(0, 0, 2, "tied1");
    convert(0, 0, 1, "tied0");
    for (int i = 0; i < 6; i++) convert(0, int'($urandom_range(0, 255)), 0, "rand_a");
    hold_test(int'($urandom_range(0, 255)));
    convert(0, int'($urandom_range(1, 255)), 0, "pre_abort");
    abort_test(int'($urandom_range(0, 255)));
    convert(0, int'($urandom_range(1, 255)), 0, "pre_reset");
    reset_test(int'($urandom_range(0, 255)));
    repeat (2) @(posedge clk);
    convert(0, int'($urandom_range(0, 255)), 0, "post_reset");

    convert(1, 'h0, 0, "b_0");
    convert(1, 'h9, 0, "b_9");
    convert(1, 'hF, 0, "b_f");
    for (int i = 0; i < 3; i++) convert(1, int'($urandom_range(0, 15)), 0, "rand_b");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sar_adc_ctrl.md
SAR_ADC_CTRL -- requirements
Module: sar_adc_ctrl

Interface
REQ-001 Parameter NBITS, default 8: conversion resolution in bits; legal range 2..12.
REQ-002 Parameter SAMPLE_CYC, default 4: number of cycles the track/hold stays in track; legal range 1..15.
REQ-003 Parameter SETTLE_CYC, default 2: DAC settle cycles per bit trial, excluding synchronizer delay; legal range 0..15.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  reset; asynchronous assert, active-low; this is fixed.
REQ-006 ena  input  1  enable; 0 aborts any activity and holds the block idle.
REQ-007 start  input  1  conversion request; sampled only in IDLE.
REQ-008 cmp_in  input  1  analog comparator output, asynchronous to clk; 1 means Vin >= Vdac.
REQ-009 sample  output  1  track/hold control to the analog pin driver; 1 = track.
REQ-010 dac_code  output  NBITS  trial code driven to the capacitive DAC.
REQ-011 busy  output  1  1 in every state except IDLE.
REQ-012 result  output  NBITS  final conversion code; held stable while valid=1.
REQ-013 valid  output  1  result available.
REQ-014 ready  input  1  consumer accepts result; handshake completes on a cycle with valid=1 and ready=1.

Function
REQ-015 cmp_in SHALL pass through a 2-flop synchronizer (cmp_s) before any use; cmp_in is never read directly.
REQ-016 States SHALL be IDLE, SAMPLE, SETTLE, DECIDE, DONE, and no others.
REQ-017 IDLE: on an edge with ena=1 and start=1, go to SAMPLE; otherwise stay; outputs sample=0, dac_code=0.
REQ-018 SAMPLE: sample=1 and dac_code=0 for exactly SAMPLE_CYC cycles; then bit index i=NBITS-1 and dac_code=(1<<i); go to SETTLE.
REQ-019 SETTLE: hold dac_code for exactly SETTLE_CYC+2 cycles, then go to DECIDE.
REQ-020 DECIDE (1 cycle): bit i of the kept code = cmp_s; all kept-code bits below i stay 0.
REQ-021 After DECIDE, if i>0: i decrements, dac_code = kept | (1<<(i-1)), go to SETTLE.
REQ-022 After DECIDE, if i==0: result loads the final kept code, valid=1, dac_code=0, go to DONE.
REQ-023 Each bit trial SHALL take SETTLE_CYC+3 cycles; with the start edge accepted at edge k, valid rises at edge k+1+SAMPLE_CYC+NBITS*(SETTLE_CYC+3).
REQ-024 DONE: valid and result SHALL be held until ready=1; that handshake edge clears valid and returns to IDLE.
REQ-025 result SHALL keep its last value after the handshake until the next DONE load.
REQ-026 start is ignored in every state except IDLE, including the handshake cycle in DONE; no request is queued.
REQ-027 ena=0 in any state: the next edge forces IDLE with sample=0, dac_code=0, valid=0 and busy=0; a partial result is discarded and result is left unchanged.
REQ-028 A code of all ones (cmp_s=1 every trial) and all zeros (cmp_s=0 every trial) SHALL both be produced without wrap or overflow.

Reset
REQ-029 rst_n=0 SHALL immediately force, asynchronously: state=IDLE, sample=0, dac_code=0, busy=0, valid=0, result=0, synchronizer flops=0, all counters=0.
REQ-030 Reset asserted mid-conversion or in DONE SHALL discard all progress; after release the first action is IDLE waiting for start.

Verification
REQ-031 Defaults, cmp_in driven as (Vin_code >= dac_code) with Vin_code=0xA5 and ready=1 -> result=0xA5, valid rises exactly 45 cycles after the start edge, and dac_code trial sequence starts 0x80, 0xC0, 0xA0, 0xB0.
REQ-032 cmp_in tied 1 -> result=0xFF; cmp_in tied 0 -> result=0x00; sample is high for exactly 4 cycles in each conversion.
REQ-033 ready held 0 for 20 cycles after valid, with start pulsed during that wait -> valid and result stay stable, no new conversion starts, IDLE is entered on the ready edge.
REQ-034 ena dropped during bit 3 trial -> next edge busy=0, dac_code=0, valid never asserts, result keeps its previous value.
REQ-035 rst_n pulsed low asynchronously, mid-cycle during SETTLE -> all outputs read 0 before the next clk edge; a subsequent start performs a full, correct conversion.
REQ-036 NBITS=4, SETTLE_CYC=0, SAMPLE_CYC=1 -> latency 1+1+4*3=14 cycles, and correct codes for inputs 0x0, 0x9 and 0xF.
